// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the unified memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   // Matches the decoder's MemRW field; 2'b00 and 2'b11 mean no access.
   localparam logic [1:0] MEMRW_READ  = 2'b10;
   localparam logic [1:0] MEMRW_WRITE = 2'b01;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - downstream memory port bundle between arbiter (master) and memory (slave)
interface mem_port_arbiter_if #(
   parameter int XLEN = 32
);
   logic              MemReq;
   logic              MemWrite;
   logic [XLEN-1:0]   MemAdr;
   logic [XLEN-1:0]   MemWdata;
   logic [XLEN/8-1:0] MemByteEn;
   logic [XLEN-1:0]   MemRdata;
   logic              MemAck;

   modport master (
      output MemReq, MemWrite, MemAdr, MemWdata, MemByteEn,
      input  MemRdata, MemAck
   );

   modport slave (
      input  MemReq, MemWrite, MemAdr, MemWdata, MemByteEn,
      output MemRdata, MemAck
   );
endinterface

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - grant decision (data first) with a streak counter that forces fetch
// after STARVE_LIMIT consecutive data grants taken while fetch was waiting.
module mem_arb_select #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic arb_en,
   input  logic ireq,
   input  logic dvalid,
   output logic grant_i,
   output logic grant_d
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] streak;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (arb_en) begin
         if (dvalid && !(ireq && streak == LIMIT)) begin
            grant_d = 1'b1;
         end else if (ireq) begin
            grant_i = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         streak <= 4'd0;
      end else if (grant_i) begin
         streak <= 4'd0;
      end else if (grant_d) begin
         if (!ireq) begin
            streak <= 4'd0;
         end else if (streak != LIMIT) begin
            streak <= streak + 4'd1;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store requests onto one memory port,
// one outstanding transaction at a time.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              IReq,
   input  logic [XLEN-1:0]   IAdr,
   output logic              IAck,
   output logic [XLEN-1:0]   IRdata,
   input  logic              DReq,
   input  logic [1:0]        DMemRW,
   input  logic [XLEN-1:0]   DAdr,
   input  logic [XLEN-1:0]   DWdata,
   input  logic [XLEN/8-1:0] DByteEn,
   output logic              DAck,
   output logic [XLEN-1:0]   DRdata,
   mem_port_arbiter_if.master mem
);
   state_t state, state_nxt;
   owner_t owner;
   logic   dvalid, dwrite, grant_i, grant_d, busy;

   assign dvalid = DReq && (DMemRW == MEMRW_READ || DMemRW == MEMRW_WRITE);
   assign dwrite = (DMemRW == MEMRW_WRITE);
   assign busy   = (state == BUSY_I) || (state == BUSY_D);

   mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
      .clk     (clk),
      .reset_n (reset_n),
      .arb_en  (state == IDLE),
      .ireq    (IReq),
      .dvalid  (dvalid),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:           if (grant_d)         state_nxt = BUSY_D;
                         else if (grant_i)    state_nxt = BUSY_I;
         BUSY_I, BUSY_D: if (mem.MemAck)      state_nxt = RESP;
         RESP:                                state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   // Request fields are latched at grant so the memory sees a stable request while busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner         <= OWN_I;
         mem.MemWrite  <= 1'b0;
         mem.MemAdr    <= '0;
         mem.MemWdata  <= '0;
         mem.MemByteEn <= '0;
         IRdata        <= '0;
         DRdata        <= '0;
      end else begin
         if (grant_d) begin
            owner         <= OWN_D;
            mem.MemWrite  <= dwrite;
            mem.MemAdr    <= DAdr;
            mem.MemWdata  <= DWdata;
            mem.MemByteEn <= dwrite ? DByteEn : '1;
         end else if (grant_i) begin
            owner         <= OWN_I;
            mem.MemWrite  <= 1'b0;
            mem.MemAdr    <= IAdr;
            mem.MemWdata  <= '0;
            mem.MemByteEn <= '1;
         end
         if (busy && mem.MemAck) begin
            if (state == BUSY_D) DRdata <= mem.MemWrite ? '0 : mem.MemRdata;
            else                 IRdata <= mem.MemRdata;
         end
      end
   end

   assign mem.MemReq = busy;
   assign IAck       = (state == RESP) && (owner == OWN_I);
   assign DAck       = (state == RESP) && (owner == OWN_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a
// transaction-level arbitration model.
module tb_mem_port_arbiter;
   localparam int XLEN  = 32;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        IReq = 1'b0;
   logic [31:0] IAdr = '0;
   logic        IAck;
   logic [31:0] IRdata;
   logic        DReq = 1'b0;
   logic [1:0]  DMemRW = 2'b00;
   logic [31:0] DAdr = '0;
   logic [31:0] DWdata = '0;
   logic [3:0]  DByteEn = '0;
   logic        DAck;
   logic [31:0] DRdata;

   int  checks = 0;
   int  errors = 0;
   int  mstreak = 0;
   byte grants[$];

   mem_port_arbiter_if #(.XLEN(XLEN)) mem ();

   mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .IReq    (IReq),
      .IAdr    (IAdr),
      .IAck    (IAck),
      .IRdata  (IRdata),
      .DReq    (DReq),
      .DMemRW  (DMemRW),
      .DAdr    (DAdr),
      .DWdata  (DWdata),
      .DByteEn (DByteEn),
      .DAck    (DAck),
      .DRdata  (DRdata),
      .mem     (mem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_check(input string tag);
      step;
      chk({tag, "_memreq"}, 32'(mem.MemReq), 32'd0);
      chk({tag, "_iack"},   32'(IAck),       32'd0);
      chk({tag, "_dack"},   32'(DAck),       32'd0);
   endtask

   // One transaction: predict the winner from the arbitration rules, then drive the memory side.
   task automatic txn(input int lat, input logic [31:0] rd);
      bit          dv, win_d, wr;
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      dv    = DReq && (DMemRW == 2'b10 || DMemRW == 2'b01);
      win_d = dv && !(IReq && mstreak == LIMIT);
      wr    = win_d && (DMemRW == 2'b01);
      ea    = win_d ? DAdr : IAdr;
      ew    = DWdata;
      eb    = wr ? DByteEn : 4'hF;
      if (win_d) mstreak = IReq ? ((mstreak < LIMIT) ? mstreak + 1 : LIMIT) : 0;
      else       mstreak = 0;

      step;
      mem.MemAck = 1'b0;
      grants.push_back((mem.MemAdr[31:28] == 4'h2) ? 8'h44 : 8'h49);
      chk("grant_memreq",   32'(mem.MemReq),    32'd1);
      chk("grant_memwrite", 32'(mem.MemWrite),  32'(wr));
      chk("grant_memadr",   mem.MemAdr,         ea);
      chk("grant_byteen",   32'(mem.MemByteEn), 32'(eb));
      if (wr) chk("grant_wdata", mem.MemWdata, ew);
      chk("streak", 32'(dut.u_sel.streak), 32'(mstreak));
      for (int j = 0; j < lat; j++) begin
         step;
         chk("busy_memreq", 32'(mem.MemReq),  32'd1);
         chk("busy_memadr", mem.MemAdr,       ea);
         chk("busy_noack",  32'(IAck | DAck), 32'd0);
      end
      mem.MemRdata = rd;
      mem.MemAck   = 1'b1;
      step;
      mem.MemAck   = 1'b0;
      chk("resp_memreq", 32'(mem.MemReq), 32'd0);
      chk("resp_dack",   32'(DAck),       32'(win_d));
      chk("resp_iack",   32'(IAck),       32'(!win_d));
      if (win_d) chk("resp_drdata", DRdata, wr ? 32'd0 : rd);
      else       chk("resp_irdata", IRdata, rd);
   endtask

   task automatic rand_d;
      int r;
      r       = $urandom_range(0, 9);
      DReq    = 1'b1;
      DMemRW  = (r < 5) ? 2'b10 : (r < 9) ? 2'b01 : 2'b00;
      DAdr    = {4'h2, 28'($urandom)};
      DWdata  = $urandom;
      DByteEn = 4'($urandom);
   endtask

   initial begin
      string exp_s;
      bit    dvalid_now;
      mem.MemAck   = 1'b0;
      mem.MemRdata = '0;

      // Reset state
      step;
      step;
      chk("rst_memreq",  32'(mem.MemReq),    32'd0);
      chk("rst_memadr",  mem.MemAdr,         32'd0);
      chk("rst_byteen",  32'(mem.MemByteEn), 32'd0);
      chk("rst_acks",    32'(IAck | DAck),   32'd0);
      chk("rst_rdata",   IRdata | DRdata,    32'd0);
      reset_n = 1'b1;
      idle_check("post_rst");

      // Reset while a D read is outstanding
      IReq = 1'b1; IAdr = 32'h1000_0040;
      DReq = 1'b1; DMemRW = 2'b10; DAdr = 32'h2000_0080;
      step;
      chk("mid_memreq", 32'(mem.MemReq), 32'd1);
      chk("mid_streak", 32'(dut.u_sel.streak), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_memreq", 32'(mem.MemReq), 32'd0);
      IReq = 1'b0; DReq = 1'b0; DMemRW = 2'b00;
      step;
      reset_n = 1'b1;
      mstreak = 0;
      for (int k = 0; k < 3; k++) idle_check("mid_after");
      chk("mid_streak_cleared", 32'(dut.u_sel.streak), 32'd0);

      // Fetch, memory answers on the second MemReq cycle
      IReq = 1'b1; IAdr = 32'h0000_0100;
      txn(1, 32'h0000_0013);
      IReq = 1'b0;
      idle_check("fetch_idle");

      // Write with immediate MemAck
      DReq = 1'b1; DMemRW = 2'b01; DAdr = 32'h0000_2000;
      DWdata = 32'hDEADBEEF; DByteEn = 4'b0011;
      txn(0, 32'hCAFE_F00D);
      DReq = 1'b0; DMemRW = 2'b00;
      idle_check("write_idle");

      // Simultaneous requests: D then I
      IReq = 1'b1; IAdr = 32'h1000_0200;
      DReq = 1'b1; DMemRW = 2'b10; DAdr = 32'h2000_0300;
      grants.delete();
      txn(1, 32'h1111_2222);
      DReq = 1'b0; DMemRW = 2'b00;
      idle_check("both_idle1");
      txn(0, 32'h3333_4444);
      IReq = 1'b0;
      idle_check("both_idle2");
      chk("both_first",  32'(grants[0]), 32'h44);
      chk("both_second", 32'(grants[1]), 32'h49);

      // Starvation bound with IReq held and DReq re-asserted every IDLE
      grants.delete();
      IReq = 1'b1; IAdr = 32'h1000_0000;
      DReq = 1'b1; DMemRW = 2'b10; DAdr = 32'h2000_0000;
      for (int n = 0; n < 10; n++) begin
         txn($urandom_range(0, 2), $urandom);
         if (grants[$] == 8'h44) DAdr = {4'h2, 28'($urandom)};
         else                    IAdr = {4'h1, 28'($urandom)};
         idle_check("starve_idle");
      end
      exp_s = "DDDDIDDDDI";
      for (int n = 0; n < 10; n++) chk("starve_order", 32'(grants[n]), 32'(exp_s[n]));
      IReq = 1'b0; DReq = 1'b0; DMemRW = 2'b00;
      idle_check("starve_done");
      mstreak = 0;

      // Invalid DMemRW encodings are not requests
      DReq = 1'b1; DMemRW = 2'b00;
      for (int k = 0; k < 4; k++) idle_check("rw00");
      DMemRW = 2'b11;
      for (int k = 0; k < 2; k++) idle_check("rw11");
      DReq = 1'b0; DMemRW = 2'b00;

      // Randomized traffic with MemAck noise outside the busy window
      for (int n = 0; n < 40; n++) begin
         dvalid_now = DReq && (DMemRW == 2'b10 || DMemRW == 2'b01);
         if (!IReq && !dvalid_now) begin
            IReq = 1'b1;
            IAdr = {4'h1, 28'($urandom)};
         end
         txn($urandom_range(0, 3), $urandom);
         if (grants[$] == 8'h44) begin
            if ($urandom_range(0, 1) == 0) begin DReq = 1'b0; DMemRW = 2'b00; end
            else rand_d();
            if (!IReq && $urandom_range(0, 1) == 1) begin IReq = 1'b1; IAdr = {4'h1, 28'($urandom)}; end
         end else begin
            if ($urandom_range(0, 1) == 0) IReq = 1'b0;
            else IAdr = {4'h1, 28'($urandom)};
            dvalid_now = DReq && (DMemRW == 2'b10 || DMemRW == 2'b01);
            if (!dvalid_now && $urandom_range(0, 1) == 1) rand_d();
         end
         mem.MemAck = 1'($urandom_range(0, 1));
         idle_check("rand_idle");
         mem.MemAck = 1'($urandom_range(0, 1));
      end
      mem.MemAck = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
